// File: rtl/int_prio_ctrl.sv
// -----------------------------------------------------------------------------
// int_prio_ctrl
//
// Parametrised interrupt controller. Latches NUM_SRC external interrupt lines
// (each edge- or level-triggered), selects the best eligible source by
// priority (ties to the lowest index), and presents it to the pipeline
// control as a single registered trap request under a req/ack handshake.
// A claim stays in service until mret retires.
//
// Optional feature: define INT_NEST_EN to allow one level of nesting. A
// strictly higher priority source may then preempt a claim in service; the
// outer claim is saved and restored on the inner mret.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_src_irq             raw interrupt lines
//   i_cfg_edge            1 = rising-edge triggered, 0 = level
//   i_cfg_en              per-source enable
//   i_cfg_prio            per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   i_cfg_thresh          a source is taken only if prio > thresh
//   i_csr_int_mie         global interrupt enable
//   i_csr_int_mtvec       trap vector, bit0 = vectored mode
//   o_int_ctrl_req        trap request to ctrl
//   i_int_ctrl_ack        ctrl accepts the trap (sampled while req = 1)
//   o_int_ctrl_mtvec      target pc of the current claim
//   o_int_csr_ecause      mcause of the current claim
//   o_int_csr_ena         one-cycle CSR update strobe after ack
//   o_int_claim_id        id (source index + 1) in request/service, 0 = none
//   o_int_pend            pending bits
//   i_de_int_mret         mret retired, completes the claim
// -----------------------------------------------------------------------------
module int_prio_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_SRC-1:0]        i_src_irq,
  input  logic [NUM_SRC-1:0]        i_cfg_edge,
  input  logic [NUM_SRC-1:0]        i_cfg_en,
  input  logic [NUM_SRC*PRIO_W-1:0] i_cfg_prio,
  input  logic [PRIO_W-1:0]         i_cfg_thresh,
  input  logic                      i_csr_int_mie,
  input  logic [31:0]               i_csr_int_mtvec,
  output logic                      o_int_ctrl_req,
  input  logic                      i_int_ctrl_ack,
  output logic [31:0]               o_int_ctrl_mtvec,
  output logic [31:0]               o_int_csr_ecause,
  output logic                      o_int_csr_ena,
  output logic [ID_W-1:0]           o_int_claim_id,
  output logic [NUM_SRC-1:0]        o_int_pend,
  input  logic                      i_de_int_mret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SERV
`ifdef INT_NEST_EN
    ,
    S_NREQ,
    S_NSERV
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;

  logic               w_best_vld;
  logic [PRIO_W-1:0]  w_best_prio;
  logic [ID_W-1:0]    w_best_idx;
  logic [ID_W-1:0]    w_best_id;
  logic [31:0]        w_best_ecause;
  logic [31:0]        w_base;
  logic [31:0]        w_best_mtvec;
  logic               w_in_req;
  logic               w_ack_take;

  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_ecause;
  logic [31:0]        r_mtvec;
  logic               r_ena;

`ifdef INT_NEST_EN
  logic [PRIO_W-1:0]  r_prio;
  logic [ID_W-1:0]    r_sv_id;
  logic [PRIO_W-1:0]  r_sv_prio;
  logic [31:0]        r_sv_ecause;
  logic [31:0]        r_sv_mtvec;
`endif

  // mtvec[1] is reserved in both modes.
  logic w_unused;
  assign w_unused = i_csr_int_mtvec[1];

  // ---------------------------------------------------------------------------
  // Source sampling and pending bits
  // ---------------------------------------------------------------------------
  // A claimed edge source is cleared when ctrl accepts it; a new edge arriving
  // in the same cycle must not be lost, so set has priority over clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_clr[i] = w_ack_take && (r_id == ID_W'(i + 1));
    end
  end

  assign w_set = i_src_irq & ~r_src_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_q <= '0;
      r_pend  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_src_q <= i_src_irq;
      r_pend  <= (i_cfg_edge & (w_set | (r_pend & ~w_clr))) |
                 (~i_cfg_edge & i_src_irq);
    end
  end

  // ---------------------------------------------------------------------------
  // Best eligible source: highest priority, ties to the lowest index (strict
  // compare while scanning upward keeps the first one found).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_elig      = '0;
    w_best_prio = '0;
    w_best_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig[i] = r_pend[i] && i_cfg_en[i] &&
                  (i_cfg_prio[i*PRIO_W +: PRIO_W] > i_cfg_thresh);
      if (w_elig[i] && (i_cfg_prio[i*PRIO_W +: PRIO_W] > w_best_prio)) begin
        w_best_prio = i_cfg_prio[i*PRIO_W +: PRIO_W];
        w_best_idx  = ID_W'(i);
      end
    end
  end

  assign w_best_vld    = |w_elig;
  assign w_best_id     = w_best_idx + ID_W'(1);
  assign w_best_ecause = {1'b1, 31'(32'd16 + 32'(w_best_idx))};
  assign w_base        = {i_csr_int_mtvec[31:2], 2'b00};
  assign w_best_mtvec  = i_csr_int_mtvec[0] ?
                         (w_base + ((32'd16 + 32'(w_best_idx)) << 2)) : w_base;

  // ---------------------------------------------------------------------------
  // Claim/complete FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef INT_NEST_EN
  assign w_in_req = (r_state == S_REQ) || (r_state == S_NREQ);
`else
  assign w_in_req = (r_state == S_REQ);
`endif
  assign w_ack_take = w_in_req && i_int_ctrl_ack;

  // Ack takes precedence over a simultaneous mie drop: ctrl has already
  // committed to the trap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_csr_int_mie && w_best_vld) w_next = S_REQ;
      end
      S_REQ: begin
        if (i_int_ctrl_ack)      w_next = S_SERV;
        else if (!i_csr_int_mie) w_next = S_IDLE;
      end
      S_SERV: begin
        if (i_de_int_mret) w_next = S_IDLE;
`ifdef INT_NEST_EN
        else if (i_csr_int_mie && w_best_vld && (w_best_prio > r_prio))
          w_next = S_NREQ;
`endif
      end
`ifdef INT_NEST_EN
      S_NREQ: begin
        if (i_int_ctrl_ack)      w_next = S_NSERV;
        else if (!i_csr_int_mie) w_next = S_SERV;
      end
      S_NSERV: begin
        if (i_de_int_mret) w_next = S_SERV;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Claim registers only change on a new claim, completion, withdraw or
  // restore, so they stay stable while the request is outstanding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id        <= '0;
      r_ecause    <= '0;
      r_mtvec     <= '0;
      r_ena       <= 1'b0;
`ifdef INT_NEST_EN
      r_prio      <= '0;
      r_sv_id     <= '0;
      r_sv_prio   <= '0;
      r_sv_ecause <= '0;
      r_sv_mtvec  <= '0;
`endif
    end else begin
      r_ena <= w_ack_take;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_REQ) begin
            r_id     <= w_best_id;
            r_ecause <= w_best_ecause;
            r_mtvec  <= w_best_mtvec;
`ifdef INT_NEST_EN
            r_prio   <= w_best_prio;
`endif
          end
        end
        S_REQ: begin
          if (w_next == S_IDLE) r_id <= '0;
        end
        S_SERV: begin
          if (w_next == S_IDLE) r_id <= '0;
`ifdef INT_NEST_EN
          else if (w_next == S_NREQ) begin
            r_sv_id     <= r_id;
            r_sv_prio   <= r_prio;
            r_sv_ecause <= r_ecause;
            r_sv_mtvec  <= r_mtvec;
            r_id        <= w_best_id;
            r_prio      <= w_best_prio;
            r_ecause    <= w_best_ecause;
            r_mtvec     <= w_best_mtvec;
          end
`endif
        end
`ifdef INT_NEST_EN
        S_NREQ, S_NSERV: begin
          if (w_next == S_SERV) begin
            r_id     <= r_sv_id;
            r_prio   <= r_sv_prio;
            r_ecause <= r_sv_ecause;
            r_mtvec  <= r_sv_mtvec;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decode directly from flops.
  always_comb begin
    o_int_ctrl_req   = w_in_req;
    o_int_ctrl_mtvec = r_mtvec;
    o_int_csr_ecause = r_ecause;
    o_int_csr_ena    = r_ena;
    o_int_claim_id   = r_id;
    o_int_pend       = r_pend;
  end

endmodule

// File: doc/int_prio_ctrl.md
# int_prio_ctrl

Parametrised interrupt controller that supersedes the fixed three-source `int_ctrl` arbitration. It latches NUM_SRC external interrupt lines, each configurable as edge- or level-triggered, with per-source enable and priority, and a global threshold. A registered claim/complete state machine sits between the sources and the pipeline control. It presents one trap request to ctrl under a req/ack handshake, drives mcause and the vectored mtvec, and holds new claims until `mret`.

## Interface
- NUM_SRC, 8, number of interrupt sources (1..31)
- PRIO_W, 3, priority field width; priority 0 = never taken
- ID_W, $clog2(NUM_SRC+1), claim id width; id = source index + 1, 0 = none
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- src_irq  in  NUM_SRC  raw interrupt lines
- cfg_edge  in  NUM_SRC  1 = rising-edge triggered, 0 = level
- cfg_en  in  NUM_SRC  per-source enable
- cfg_prio  in  NUM_SRC*PRIO_W  priority of source i at bits [i*PRIO_W +: PRIO_W]
- cfg_thresh  in  PRIO_W  source is taken only if prio > thresh
- csr_int_mie  in  1  global interrupt enable
- csr_int_mtvec  in  32  trap vector; bit0 = vectored mode
- int_ctrl_req  out  1  registered trap request to ctrl
- int_ctrl_ack  in  1  ctrl accepts trap (sampled while req = 1)
- int_ctrl_mtvec  out  32  target pc for the current claim
- int_csr_ecause  out  32  mcause for the current claim
- int_csr_ena  out  1  one-cycle CSR update strobe
- int_claim_id  out  ID_W  id of the claim in request or service
- int_pend  out  NUM_SRC  pending bits
- de_int_mret  in  1  mret retired (completion)

## Operation
- Pending: edge source i sets on `src_irq[i] & ~src_q[i]` and clears on ack of its claim. Set wins if set and clear occur in the same cycle. A level source's pending bit is the registered `src_irq[i]`.
- Eligible: `pend & cfg_en & (prio > cfg_thresh)`. Best eligible is the highest prio; ties go to the lowest index.
- ecause = {1'b1, 31'(16 + index)}.
- int_ctrl_mtvec:
  - Direct mode: {mtvec[31:2], 2'b00}.
  - Vectored mode: {mtvec[31:2], 2'b00} + 4*(16 + index), 32-bit wrap.
- FSM:
  - IDLE: when mie = 1 and any source is eligible, latch id/prio/ecause/mtvec, set req, go to REQ.
  - REQ: hold req and all claim outputs stable.
    - On ack: clear req, clear the claimed edge pending bit, pulse int_csr_ena next cycle, go to SERV.
    - If mie falls before ack: clear req, go to IDLE.
  - SERV: no new claim. On de_int_mret: go to IDLE and clear int_claim_id.
- A level source that deasserts during REQ does not withdraw the claim; the claim is committed.
- de_int_mret in IDLE or REQ is ignored.

## Timing
- Reset: state IDLE, src_q = 0, pend = 0; all outputs 0.
- Because src_q resets to 0, a line already high when rst releases counts as an edge.
- Latency: src_irq rises before edge t0 → pend set at t0 → int_ctrl_req high after t1 (2 edges).
- Ack sampled at edge t: req low after t, int_csr_ena high for the single cycle after t, state SERV after t.
- mret at edge t: IDLE after t. A new req is possible after t+1 at the earliest.
- rst asserted mid-operation clears everything immediately, including mid-REQ and mid-SERV.

## Configuration
- INT_NEST_EN defined: one nesting level.
  - In SERV, a source whose prio is strictly greater than the serviced prio (and mie = 1) takes states NREQ → NSERV with the same req/ack rules. The outer id/prio/ecause are saved.
  - mret in NSERV restores the saved claim and returns to SERV.
  - No further nesting from NSERV.
- INT_NEST_EN undefined: SERV ignores all sources until mret, and the NREQ/NSERV states and save registers are absent.

## Test plan
- Edge, single source: src 2 prio 3, thresh 0, mie 1, pulse src 1 cycle → req after 2 edges, id 3, ecause 0x8000_0012. Ack → ena one cycle, pend[2] = 0.
- Arbitration: src 1 and src 5 both prio 4, src 6 prio 6, all raised together → id 7. After mret, id 2, then id 6.
- Vectored mode: mtvec 0x8000_0001, src 0 → int_ctrl_mtvec 0x8000_0040. Threshold 4 with src prio 4 → no req.
- Withdraw: req pending, drop mie before ack → req low next cycle, state IDLE. Level src still high and mie re-raised → req again after 1 edge.
- Simultaneous events: edge re-arrives on the same cycle as ack of that source → pend stays 1 and the source is re-claimed after mret. Reset asserted in SERV → all outputs 0 asynchronously.
- INT_NEST_EN: serving prio 2, src prio 5 raised → req in SERV. Ack then mret → int_claim_id returns to the outer id, state SERV. Without the macro → no req until the first mret.
